// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - serial pattern scanner over a captured 16-bit word
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      scan request (IDLE only)      abort    cancel a scan in SHIFT
//   data_in    16-bit word, scanned MSB first
//   pat        right-aligned target pattern  pat_len  pattern length, legal 3..6
//   ser_bit    bit under test this cycle     busy     high in SHIFT
//   done       one-cycle completion pulse    err      illegal pat_len on last request
//   match_cnt  matches in last scan          found    at least one match
//   first_pos  bit index of first match      st       IDLE=0 SHIFT=1 DONE=2
module seq_scan_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] data_in,
  input  logic [5:0]  pat,
  input  logic [2:0]  pat_len,
  output logic        ser_bit,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  match_cnt,
  output logic        found,
  output logic [3:0]  first_pos,
  output logic [1:0]  st
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [5:0]  pat_q, pat_d;
  logic [2:0]  len_q, len_d;
  // Only five history bits are kept: the sixth-oldest bit never takes part
  // in a comparison because the new bit is appended before matching.
  logic [4:0]  hist_q, hist_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        found_q, found_d;
  logic [3:0]  pos_q, pos_d;
  logic        err_q, err_d;

  logic        ser_c;
  logic [5:0]  hist_new;
  logic [6:0]  mask7;
  logic [5:0]  mask;
  logic        len_legal;
  logic        enough_bits;
  logic        match;

  assign len_legal   = (pat_len >= 3'd3) && (pat_len <= 3'd6);
  assign ser_c       = (state_q == S_SHIFT) ? word_q[4'd15 - idx_q] : 1'b0;
  assign hist_new    = {hist_q, ser_c};
  // Computed one bit wider so that pat_len=6 yields an all-ones mask.
  assign mask7       = (7'd1 << len_q) - 7'd1;
  assign mask        = mask7[5:0];
  assign enough_bits = ({1'b0, idx_q} + 5'd1) >= {2'b00, len_q};
  assign match       = enough_bits && (((hist_new ^ pat_q) & mask) == 6'd0);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    pos_d   = pos_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        // start outranks abort here; abort has no meaning in IDLE
        if (start) begin
          cnt_d   = 5'd0;
          found_d = 1'b0;
          pos_d   = 4'd0;
          if (len_legal) begin
            word_d  = data_in;
            pat_d   = pat;
            len_d   = pat_len;
            hist_d  = 5'd0;
            idx_d   = 4'd0;
            err_d   = 1'b0;
            state_d = S_SHIFT;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_SHIFT: begin
        if (abort) begin
          cnt_d   = 5'd0;
          found_d = 1'b0;
          pos_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          hist_d = hist_new[4:0];
          idx_d  = idx_q + 4'd1;
          if (match) begin
            if (cnt_q != 5'd31) begin
              cnt_d = cnt_q + 5'd1;
            end
            if (!found_q) begin
              found_d = 1'b1;
              pos_d   = idx_q;
            end
          end
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= 16'd0;
      pat_q   <= 6'd0;
      len_q   <= 3'd0;
      hist_q  <= 5'd0;
      idx_q   <= 4'd0;
      cnt_q   <= 5'd0;
      found_q <= 1'b0;
      pos_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
    end
  end

  assign ser_bit   = ser_c;
  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign match_cnt = cnt_q;
  assign found     = found_q;
  assign first_pos = pos_q;
  assign st        = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - randomized self-checking bench for seq_scan_ctrl
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] data_in;
  logic [5:0]  pat;
  logic [2:0]  pat_len;
  logic        ser_bit;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  match_cnt;
  logic        found;
  logic [3:0]  first_pos;
  logic [1:0]  st;

  int n_checks = 0;
  int n_fail   = 0;

  seq_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .data_in   (data_in),
    .pat       (pat),
    .pat_len   (pat_len),
    .ser_bit   (ser_bit),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .match_cnt (match_cnt),
    .found     (found),
    .first_pos (first_pos),
    .st        (st)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: slide a pat_len-wide window over the serial bit stream and
  // compare it directly against the pattern bits.
  task automatic model(input logic [15:0] w, input logic [5:0] p, input int l,
                       output int cnt, output int fnd, output int pos, output int e);
    cnt = 0; fnd = 0; pos = 0; e = 0;
    if (l < 3 || l > 6) begin
      e = 1;
      return;
    end
    for (int k = l - 1; k < 16; k++) begin
      int ok;
      ok = 1;
      for (int j = 0; j < l; j++) begin
        if (w[15 - (k - j)] != p[j]) ok = 0;
      end
      if (ok == 1) begin
        if (cnt == 0) begin
          fnd = 1;
          pos = k;
        end
        cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_st"},    st,        0);
    check_eq({tag, "_busy"},  busy,      0);
    check_eq({tag, "_done"},  done,      0);
    check_eq({tag, "_err"},   err,       0);
    check_eq({tag, "_ser"},   ser_bit,   0);
    check_eq({tag, "_cnt"},   match_cnt, 0);
    check_eq({tag, "_found"}, found,     0);
    check_eq({tag, "_pos"},   first_pos, 0);
  endtask

  // Launches one request from IDLE and follows it to completion.
  // Called at #1 after an edge with the DUT idle.
  task automatic run_scan(input string tag, input logic [15:0] w, input logic [5:0] p,
                          input logic [2:0] l, input bit poke_start, input bit with_abort);
    int cnt, fnd, pos, e, edges;
    model(w, p, int'(l), cnt, fnd, pos, e);
    data_in = w; pat = p; pat_len = l;
    start = 1'b1;
    abort = with_abort;
    step();                         // E0
    edges = 1;
    start = 1'b0;
    abort = 1'b0;
    data_in = 16'($urandom);        // must not disturb the running scan
    pat     = 6'($urandom);
    pat_len = 3'($urandom);
    while (!done && edges < 40) begin
      if (busy) check_eq({tag, "_ser"}, ser_bit, w[15 - (edges - 1)]);
      if (poke_start && edges == 6) start = 1'b1;
      if (poke_start && edges == 8) start = 1'b0;
      step();
      edges++;
    end
    check_eq({tag, "_done_seen"}, done, 1);
    check_eq({tag, "_latency"},   edges, (e != 0) ? 1 : 17);
    check_eq({tag, "_ser_done"},  ser_bit, 0);
    check_eq({tag, "_err"},       err, e);
    check_eq({tag, "_cnt"},       match_cnt, cnt);
    check_eq({tag, "_found"},     found, fnd);
    check_eq({tag, "_pos"},       first_pos, pos);
    step();
    check_eq({tag, "_st_idle"},   st, 0);
    check_eq({tag, "_done_once"}, done, 0);
    check_eq({tag, "_cnt_hold"},  match_cnt, cnt);
    check_eq({tag, "_err_hold"},  err, e);
    step();
    check_eq({tag, "_no_redo"},   done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    data_in = 16'h0; pat = 6'h0; pat_len = 3'd0;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    run_scan("vec_bde0", 16'hBDE0, 6'b101111, 3'd6, 1'b0, 1'b0);
    run_scan("vec_aaaa", 16'hAAAA, 6'b000101, 3'd3, 1'b0, 1'b0);
    run_scan("vec_zero", 16'h0000, 6'b101111, 3'd6, 1'b0, 1'b0);
    run_scan("len2_err", 16'hFFFF, 6'b000111, 3'd2, 1'b0, 1'b0);
    run_scan("clr_err",  16'hBDE0, 6'b101111, 3'd6, 1'b0, 1'b0);
    run_scan("len7_err", 16'h1234, 6'b010101, 3'd7, 1'b0, 1'b0);
    run_scan("max_cnt",  16'h0000, 6'b000000, 3'd3, 1'b0, 1'b0);
    run_scan("poke",     16'hAAAA, 6'b000101, 3'd3, 1'b1, 1'b0);
    run_scan("st_ab",    16'hBDE0, 6'b101111, 3'd6, 1'b0, 1'b1);

    // Abort sampled on the edge ending the 5th SHIFT cycle, after one match.
    data_in = 16'hAAAA; pat = 6'b000101; pat_len = 3'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("abort_pre_cnt", match_cnt, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all_zero("abort");
    for (int i = 0; i < 20; i++) begin
      if (done) check_eq("abort_no_done", done, 0);
      step();
    end
    check_eq("abort_st", st, 0);

    // Reset in the middle of a scan that has already matched once.
    data_in = 16'hBDE0; pat = 6'b101111; pat_len = 3'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_eq("rst_pre_found", found, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midrst");
    for (int i = 0; i < 20; i++) begin
      if (done) check_eq("midrst_no_done", done, 0);
      step();
    end
    run_scan("after_rst", 16'hBDE0, 6'b101111, 3'd6, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [15:0] w;
      logic [5:0]  p;
      logic [2:0]  l;
      w = 16'($urandom);
      p = 6'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(3, 6));
      // Bias some words toward repeating patterns to exercise overlap.
      if (t % 3 == 0) w = {p[3:0], p[3:0], p[3:0], p[3:0]};
      run_scan("rand", w, p, l, t[0], t[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 start  input  1  scan request, sampled only in IDLE.
REQ-005 abort  input  1  cancels a scan in progress.
REQ-006 data_in  input  16  word to scan, serialised MSB first (bit index k = data_in[15-k]).
REQ-007 pat  input  6  target pattern, right-aligned: the last serial bit of the match equals pat[0].
REQ-008 pat_len  input  3  pattern length; the legal range is 3..6.
REQ-009 ser_bit  output  1  serial bit presented this cycle (observation only).
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  illegal pat_len flag for the last request.
REQ-013 match_cnt  output  5  number of matches in the last scan.
REQ-014 found  output  1  at least one match in the last scan.
REQ-015 first_pos  output  4  bit index k that completed the first match.
REQ-016 st  output  2  current state: IDLE=0, SHIFT=1, DONE=2.

Function
REQ-017 The state machine SHALL have states IDLE, SHIFT and DONE; the encoding 3 SHALL return to IDLE on the next edge.
REQ-018 IDLE, start=1 and 3<=pat_len<=6: the block SHALL capture data_in, pat and pat_len, clear the history, match_cnt, found, first_pos and err, and go to SHIFT.
REQ-019 IDLE, start=1 and pat_len outside 3..6: the block SHALL set err=1, clear match_cnt, found and first_pos, and go directly to DONE.
REQ-020 IDLE, start=0: the block SHALL stay in IDLE with all results held.
REQ-021 In SHIFT, ser_bit SHALL equal bit k of the captured word, where k is the current bit index; ser_bit SHALL be 0 outside SHIFT.
REQ-022 On each SHIFT edge, the history register SHALL become {hist[4:0], ser_bit} and the bit index SHALL increment.
REQ-023 A match at bit k SHALL occur when k+1 >= pat_len and the low pat_len bits of the new history equal the low pat_len bits of pat; overlapping matches SHALL count.
REQ-024 On a match, match_cnt SHALL increment; on the first match of a scan, found SHALL go to 1 and first_pos SHALL be set to k.
REQ-025 match_cnt SHALL NOT wrap: the maximum is 14 matches (pat_len=3).
REQ-026 After processing bit 15, the block SHALL go to DONE.
REQ-027 Latency: with start sampled on edge E0, bits SHALL be processed on edges E1..E16, done SHALL be high for the single cycle between E16 and E17, and st SHALL be IDLE after E17.
REQ-028 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-029 In DONE and IDLE, match_cnt, found, first_pos and err SHALL hold until the next accepted start or reset.
REQ-030 start while in SHIFT or DONE SHALL be ignored; it is not queued.
REQ-031 abort=1 in SHIFT SHALL send the block to IDLE on that edge with match_cnt, found and first_pos cleared, and done SHALL NOT pulse.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 If abort and start are both high in IDLE, start SHALL win.
REQ-034 Inputs SHALL be sampled only at capture; changes to data_in, pat or pat_len during SHIFT SHALL NOT affect the scan in progress.

Reset
REQ-035 rst=1 on a clock edge SHALL force st=IDLE and busy=0, done=0, err=0, ser_bit=0, match_cnt=0, found=0, first_pos=0, and clear the history and bit index.
REQ-036 rst SHALL take priority over start and abort, including during SHIFT and DONE; no done pulse SHALL follow a reset.

Verification
REQ-037 data_in=0xBDE0, pat=6'b101111, pat_len=6, start pulse -> done exactly 17 cycles after the start edge, match_cnt=2, found=1, first_pos=5, err=0.
REQ-038 data_in=0xAAAA, pat=6'b000101, pat_len=3 -> overlapping matches give match_cnt=7, first_pos=2, found=1.
REQ-039 data_in=0x0000, pat=6'b101111, pat_len=6 -> match_cnt=0, found=0, first_pos=0, done after 17 cycles.
REQ-040 pat_len=2 with start -> done 1 cycle after the start edge, err=1, match_cnt=0; the next legal start then clears err.
REQ-041 abort at the 5th SHIFT cycle -> st=IDLE next cycle, no done, results=0; a start issued during SHIFT -> ignored, with done occurring only once.
REQ-042 rst asserted mid-SHIFT after a match -> all outputs 0 and st=IDLE on the next edge; the following normal scan gives the REQ-037 results.
